fighter_action_fsm: RTL and testbench

Per-player action controller that turns debounced key inputs and a hit indication into the `character1_state`, `frame_num`, `move_l` and `move_r` signals consumed by the sprite/position stage. It sits directly upstream of the character sprite block. It runs on the 50 MHz system clock and advances animation only on rising edges of the ~60 Hz `frame_clk`.

---
 rtl/fighter_action_fsm.sv | 161 ++++++++++++++++
 tb/tb_fighter_action_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_action_fsm.sv
// Per-player action controller: turns key levels and opponent hits into the
// character state, animation frame index and movement/strike/block pulses.
module fighter_action_fsm #(
    parameter int unsigned TICKS_PER_FRAME = 4,
    parameter int unsigned N_STAND         = 8,
    parameter int unsigned N_MOVE          = 5,
    parameter int unsigned N_ATTACK        = 9,
    parameter int unsigned N_HURT          = 4,
    parameter int unsigned N_DEFEND        = 1,
    parameter int unsigned STRIKE_FRAME    = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       key_defend,
    input  logic       hit_in,
    output logic [7:0] character1_state,
    output logic [7:0] frame_num,
    output logic       move_l,
    output logic       move_r,
    output logic       strike,
    output logic       blocked
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DIV_LAST   = CW'(TICKS_PER_FRAME - 1);
    localparam logic [CW-1:0] STRIKE_IDX = CW'(STRIKE_FRAME);

    typedef enum logic [CW-1:0] {
        ST_STAND  = 8'd0,
        ST_ATTACK = 8'd1,
        ST_MOVEL  = 8'd2,
        ST_MOVER  = 8'd3,
        ST_HURT   = 8'd4,
        ST_DEFEND = 8'd5
    } state_e;

    logic          sync1_q, sync2_q, prev_q, tick_q, tick_d;
    state_e        state_q, state_d, next_state, key_state;
    logic [CW-1:0] frame_q, frame_d, div_q, div_d;
    logic          hit_pending_q, hit_pending_d, pend;
    logic          move_l_q, move_l_d, move_r_q, move_r_d;
    logic          strike_q, strike_d, blocked_q, blocked_d;
    logic          div_wrap, frame_last;

    function automatic logic [CW-1:0] last_frame(input state_e s);
        case (s)
            ST_STAND:  return CW'(N_STAND - 1);
            ST_ATTACK: return CW'(N_ATTACK - 1);
            ST_MOVEL:  return CW'(N_MOVE - 1);
            ST_MOVER:  return CW'(N_MOVE - 1);
            ST_HURT:   return CW'(N_HURT - 1);
            ST_DEFEND: return CW'(N_DEFEND - 1);
            default:   return '0;
        endcase
    endfunction

    // Rising-edge detect on the synchronized frame clock, registered once more.
    assign tick_d = sync2_q & ~prev_q;

    // Key decode for the freely re-selectable states.
    always_comb begin
        key_state = ST_STAND;
        if (key_attack) begin
            key_state = ST_ATTACK;
        end else if (key_defend) begin
            key_state = ST_DEFEND;
        end else if (key_right && !key_left) begin
            key_state = ST_MOVER;
        end else if (key_left && !key_right) begin
            key_state = ST_MOVEL;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        div_d         = div_q;
        next_state    = state_q;
        hit_pending_d = hit_pending_q | hit_in;
        move_l_d      = 1'b0;
        move_r_d      = 1'b0;
        strike_d      = 1'b0;
        blocked_d     = 1'b0;
        pend          = hit_pending_q | hit_in;
        div_wrap      = (div_q == DIV_LAST);
        frame_last    = (frame_q == last_frame(state_q));

        if (tick_q) begin
            hit_pending_d = 1'b0;
            move_r_d      = (state_q == ST_MOVER);
            move_l_d      = (state_q == ST_MOVEL);

            if (pend && state_q == ST_DEFEND) begin
                blocked_d  = 1'b1;
                next_state = ST_DEFEND;
            end else if (pend && state_q != ST_HURT) begin
                next_state = ST_HURT;
            end else if (state_q == ST_HURT || state_q == ST_ATTACK) begin
                next_state = (frame_last && div_wrap) ? ST_STAND : state_q;
            end else begin
                next_state = key_state;
            end

            if (next_state != state_q) begin
                state_d = next_state;
                frame_d = '0;
                div_d   = '0;
            end else begin
                div_d = div_wrap ? '0 : div_q + 8'd1;
                if (div_wrap) begin
                    frame_d = frame_last ? '0 : frame_q + 8'd1;
                end
            end

            strike_d = (state_d == ST_ATTACK) && (frame_d == STRIKE_IDX) &&
                       ((state_q != ST_ATTACK) || (frame_q != STRIKE_IDX));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            tick_q        <= 1'b0;
            state_q       <= ST_STAND;
            frame_q       <= '0;
            div_q         <= '0;
            hit_pending_q <= 1'b0;
            move_l_q      <= 1'b0;
            move_r_q      <= 1'b0;
            strike_q      <= 1'b0;
            blocked_q     <= 1'b0;
        end else begin
            sync1_q       <= frame_clk;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            tick_q        <= tick_d;
            state_q       <= state_d;
            frame_q       <= frame_d;
            div_q         <= div_d;
            hit_pending_q <= hit_pending_d;
            move_l_q      <= move_l_d;
            move_r_q      <= move_r_d;
            strike_q      <= strike_d;
            blocked_q     <= blocked_d;
        end
    end

    assign character1_state = state_q;
    assign frame_num        = frame_q;
    assign move_l           = move_l_q;
    assign move_r           = move_r_q;
    assign strike           = strike_q;
    assign blocked          = blocked_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Bench for fighter_action_fsm: directed vector table, hand-written corner
// sequences and random key/hit traffic against an elapsed-ticks model.
module tb_fighter_action_fsm;

    localparam int TPF = 4, NST = 8, NMV = 5, NAT = 9, NHU = 4, NDF = 1, STRK = 5;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, key_left, key_right, key_attack, key_defend, hit_in;
    logic [7:0] character1_state, frame_num;
    logic       move_l, move_r, strike, blocked;

    int n_checks = 0, n_fail = 0;
    int c_mr = 0, c_ml = 0, c_st = 0, c_bl = 0, c_both = 0;

    // Model: state code, ticks elapsed in state (mod loop length), pending hit.
    int m_st, m_e;
    bit m_pend;
    bit e_mr, e_ml, e_st, e_bl;

    typedef struct {
        bit kl, kr, ka, kd, hit;
        int st, fr;
        bit mr, ml, bl;
    } vec_t;
    vec_t tbl[11];

    always #10 Clk = ~Clk;

    fighter_action_fsm #(
        .TICKS_PER_FRAME(TPF), .N_STAND(NST), .N_MOVE(NMV), .N_ATTACK(NAT),
        .N_HURT(NHU), .N_DEFEND(NDF), .STRIKE_FRAME(STRK)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .key_left(key_left), .key_right(key_right), .key_attack(key_attack),
        .key_defend(key_defend), .hit_in(hit_in),
        .character1_state(character1_state), .frame_num(frame_num),
        .move_l(move_l), .move_r(move_r), .strike(strike), .blocked(blocked)
    );

    // Cumulative pulse-cycle counters; a pulse of width w adds w.
    always @(negedge Clk) begin
        if (move_r) c_mr++;
        if (move_l) c_ml++;
        if (strike) c_st++;
        if (blocked) c_bl++;
        if (move_r && move_l) c_both++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nfr(input int s);
        case (s)
            0: return NST;
            1: return NAT;
            2, 3: return NMV;
            4: return NHU;
            default: return NDF;
        endcase
    endfunction

    function automatic void m_reset();
        m_st = 0; m_e = 0; m_pend = 0;
    endfunction

    function automatic void m_tick(input bit kl, input bit kr, input bit ka, input bit kd);
        int nxt;
        e_mr = (m_st == 3);
        e_ml = (m_st == 2);
        e_bl = 0;
        if (m_pend && m_st == 5) begin
            e_bl = 1; nxt = 5;
        end else if (m_pend && m_st != 4) nxt = 4;
        else if (m_st == 4 || m_st == 1) nxt = (m_e + 1 == nfr(m_st) * TPF) ? 0 : m_st;
        else if (ka) nxt = 1;
        else if (kd) nxt = 5;
        else if (kr && !kl) nxt = 3;
        else if (kl && !kr) nxt = 2;
        else nxt = 0;
        m_pend = 0;
        if (nxt != m_st) begin
            m_st = nxt; m_e = 0;
        end else begin
            m_e = (m_e + 1) % (nfr(m_st) * TPF);
        end
        e_st = (m_st == 1 && m_e == STRK * TPF);
    endfunction

    task automatic set_keys(input bit kl, input bit kr, input bit ka, input bit kd);
        key_left = kl; key_right = kr; key_attack = ka; key_defend = kd;
    endtask

    task automatic pulse_hit();
        hit_in = 1'b1;
        @(negedge Clk);
        hit_in = 1'b0;
        @(negedge Clk);
        m_pend = 1;
    endtask

    // One frame_clk period (one tick), then compare against the model.
    task automatic do_tick();
        int mr0, ml0, st0, bl0, b0;
        mr0 = c_mr; ml0 = c_ml; st0 = c_st; bl0 = c_bl; b0 = c_both;
        m_tick(key_left, key_right, key_attack, key_defend);
        frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        chk("state", int'(character1_state), m_st);
        chk("frame", int'(frame_num), m_e / TPF);
        chk("move_r", c_mr - mr0, int'(e_mr));
        chk("move_l", c_ml - ml0, int'(e_ml));
        chk("strike", c_st - st0, int'(e_st));
        chk("blocked", c_bl - bl0, int'(e_bl));
        chk("both_moves", c_both - b0, 0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        hit_in = 1'b0;
        set_keys(0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        m_reset();
    endtask

    initial begin
        int n, mr0, st0, bl0;
        //          kl kr ka kd hit st fr mr ml bl
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 3, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 3, 0, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 5, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 5, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 2, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 4, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 4, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 4, 0, 0, 0, 0};

        Reset_n = 1'b0;
        frame_clk = 1'b0;
        hit_in = 1'b0;
        set_keys(0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        chk("rst_state", int'(character1_state), 0);
        chk("rst_frame", int'(frame_num), 0);
        chk("rst_pulses", int'({move_l, move_r, strike, blocked}), 0);
        do_reset();

        // Directed vector table from reset.
        for (int i = 0; i < 11; i++) begin
            set_keys(tbl[i].kl, tbl[i].kr, tbl[i].ka, tbl[i].kd);
            if (tbl[i].hit) pulse_hit();
            mr0 = c_mr; n = c_ml; bl0 = c_bl;
            do_tick();
            chk($sformatf("tbl%0d_state", i), int'(character1_state), tbl[i].st);
            chk($sformatf("tbl%0d_frame", i), int'(frame_num), tbl[i].fr);
            chk($sformatf("tbl%0d_mr", i), c_mr - mr0, int'(tbl[i].mr));
            chk($sformatf("tbl%0d_ml", i), c_ml - n, int'(tbl[i].ml));
            chk($sformatf("tbl%0d_bl", i), c_bl - bl0, int'(tbl[i].bl));
        end

        // Idle loop.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            do_tick();
            if (i == 27) chk("idle_frame7", int'(frame_num), 7);
            if (i == 31) chk("idle_wrap", int'(frame_num), 0);
        end
        chk("idle_end_frame", int'(frame_num), 2);

        // Walk right.
        set_keys(0, 1, 0, 0);
        mr0 = c_mr; n = c_ml;
        for (int i = 0; i < 10; i++) do_tick();
        chk("walk_mr_count", c_mr - mr0, 9);
        chk("walk_ml_count", c_ml - n, 0);

        // Attack one-shot with key_right held throughout.
        set_keys(0, 1, 1, 0);
        st0 = c_st;
        do_tick();
        set_keys(0, 1, 0, 0);
        n = (character1_state == 8'd1) ? 1 : 0;
        for (int i = 0; i < 45; i++) begin
            do_tick();
            if (character1_state != 8'd1) break;
            n++;
        end
        chk("attack_ticks", n, 36);
        chk("attack_end_state", int'(character1_state), 0);
        chk("attack_end_frame", int'(frame_num), 0);
        chk("attack_strikes", c_st - st0, 1);
        do_tick();
        chk("post_attack_mover", int'(character1_state), 3);

        // Hit during mover, second hit ignored during hurt.
        pulse_hit();
        do_tick();
        chk("hit_to_hurt", int'(character1_state), 4);
        mr0 = c_mr;
        n = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) pulse_hit();
            do_tick();
            if (character1_state == 8'd4) n++;
        end
        chk("hurt_ticks", n, 16);
        chk("hurt_no_move", c_mr - mr0, 0);
        chk("hurt_exit", int'(character1_state), 0);

        // Defend absorbs a hit; left+right together falls back to stand.
        set_keys(0, 0, 0, 1);
        do_tick();
        bl0 = c_bl;
        pulse_hit();
        do_tick();
        do_tick();
        chk("defend_state", int'(character1_state), 5);
        chk("defend_blocks", c_bl - bl0, 1);
        set_keys(1, 1, 0, 0);
        do_tick();
        chk("lr_both_stand", int'(character1_state), 0);

        // Asynchronous reset in the middle of an attack.
        set_keys(0, 0, 1, 0);
        do_tick();
        set_keys(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) do_tick();
        chk("pre_reset_frame", int'(frame_num), 3);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_state", int'(character1_state), 0);
        chk("async_rst_frame", int'(frame_num), 0);
        chk("async_rst_pulses", int'({move_l, move_r, strike, blocked}), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        m_reset();

        // frame_clk already high at reset release: exactly one tick.
        Reset_n = 1'b0;
        frame_clk = 1'b1;
        set_keys(0, 1, 0, 0);
        repeat (2) @(negedge Clk);
        m_reset();
        Reset_n = 1'b1;
        mr0 = c_mr;
        repeat (20) @(negedge Clk);
        chk("high_rel_state", int'(character1_state), 3);
        chk("high_rel_one_tick", c_mr - mr0, 0);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        m_tick(0, 1, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            set_keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) pulse_hit();
            do_tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
